death_manager: RTL



---
 rtl/death_manager.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/death_manager.sv
// ---------------------------------------------------------------------------
// death_manager
//
// Per-level life/death controller for the kid. It combines the hazard
// collision flags and a fall-off-screen check into one death event. On a
// death it freezes play for FREEZE_FRAMES frames, then shows game over and
// waits for a fresh press of the restart key. A restart holds level_rst
// high for RESET_CYCLES clocks so every hazard block is reset. On the first
// of those clocks it pulses spawn_load so the kid block reloads its spawn
// point. The block also counts deaths (saturating at 9999) and records the
// cause of the most recent death.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   frame_tick   one-clk pulse per video frame
//   hit_vec      is_collide from each hazard, bit i = hazard i
//   kid_y        current kid y position
//   respawn_key  restart key level (already synchronised)
//   kid_dead     high while DYING or DEAD; freezes kid motion
//   game_over    high while DEAD; enables the overlay
//   level_rst    reset to every hazard block
//   spawn_load   one-cycle pulse; kid block loads spawn_x / spawn_y
//   spawn_x/y    constant respawn coordinates
//   death_count  deaths since reset, saturating at 9999
//   last_cause   lowest hit hazard index, or NUM_HAZARDS for a fall
//
// Leaving reset is handled exactly like a restart-key press. The first clock
// edge after rst is released plays the role of the key edge: spawn_load
// pulses and level_rst is then held for RESET_CYCLES cycles.
// ---------------------------------------------------------------------------
module death_manager #(
    parameter int NUM_HAZARDS   = 4,
    parameter int SPAWN_X       = 40,
    parameter int SPAWN_Y       = 540,
    parameter int FREEZE_FRAMES = 30,
    parameter int RESET_CYCLES  = 4,
    parameter int SCREEN_H      = 600
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 frame_tick,
    input  logic [NUM_HAZARDS-1:0]               hit_vec,
    input  logic [9:0]                           kid_y,
    input  logic                                 respawn_key,
    output logic                                 kid_dead,
    output logic                                 game_over,
    output logic                                 level_rst,
    output logic                                 spawn_load,
    output logic [9:0]                           spawn_x,
    output logic [9:0]                           spawn_y,
    output logic [13:0]                          death_count,
    output logic [$clog2(NUM_HAZARDS+1)-1:0]     last_cause
);

    localparam int CW = $clog2(NUM_HAZARDS + 1);

    // The frame counter only needs to reach FREEZE_FRAMES-1.
    // The reset counter only needs to reach RESET_CYCLES-1.
    localparam int FW = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [FW-1:0] FF_LAST = FW'((FREEZE_FRAMES > 0) ? FREEZE_FRAMES - 1 : 0);
    localparam logic [RW-1:0] RC_LAST = RW'((RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0);
    localparam logic [13:0]   COUNT_MAX = 14'd9999;

    localparam logic [1:0] ST_ALIVE   = 2'd0;
    localparam logic [1:0] ST_DYING   = 2'd1;
    localparam logic [1:0] ST_DEAD    = 2'd2;
    localparam logic [1:0] ST_RESPAWN = 2'd3;

    logic [1:0]    state_reg,       state_next;
    logic [RW-1:0] rst_cnt_reg,     rst_cnt_next;
    logic [FW-1:0] frame_cnt_reg,   frame_cnt_next;
    logic          boot_reg,        boot_next;
    logic          key_prev_reg,    key_prev_next;
    logic          kid_dead_reg,    kid_dead_next;
    logic          game_over_reg,   game_over_next;
    logic          level_rst_reg,   level_rst_next;
    logic          spawn_load_reg,  spawn_load_next;
    logic [13:0]   death_count_reg, death_count_next;
    logic [CW-1:0] last_cause_reg,  last_cause_next;

    logic          key_edge;
    logic          fall;
    logic          any_hit;
    logic          death;
    logic [CW-1:0] cause;

    assign key_edge = respawn_key & ~key_prev_reg;
    assign fall     = (32'(kid_y) >= 32'(SCREEN_H));
    assign any_hit  = |hit_vec;
    assign death    = any_hit | fall;

    // Lowest set hazard index wins. The default of NUM_HAZARDS covers
    // the fall-only case: with no hazard hit, a death can only be a fall.
    always_comb begin
        cause = CW'(NUM_HAZARDS);
        for (int i = NUM_HAZARDS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                cause = CW'(i);
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        rst_cnt_next     = rst_cnt_reg;
        frame_cnt_next   = frame_cnt_reg;
        boot_next        = boot_reg;
        key_prev_next    = respawn_key;
        kid_dead_next    = kid_dead_reg;
        game_over_next   = game_over_reg;
        level_rst_next   = level_rst_reg;
        spawn_load_next  = 1'b0;
        death_count_next = death_count_reg;
        last_cause_next  = last_cause_reg;

        case (state_reg)
            ST_RESPAWN: begin
                if (boot_reg) begin
                    // First edge after reset release acts as the restart edge.
                    boot_next       = 1'b0;
                    spawn_load_next = 1'b1;
                    level_rst_next  = 1'b1;
                    rst_cnt_next    = '0;
                end else if (rst_cnt_reg == RC_LAST) begin
                    state_next     = ST_ALIVE;
                    level_rst_next = 1'b0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 1'b1;
                end
            end

            ST_ALIVE: begin
                if (death) begin
                    state_next      = ST_DYING;
                    kid_dead_next   = 1'b1;
                    frame_cnt_next  = '0;
                    last_cause_next = cause;
                    if (death_count_reg != COUNT_MAX) begin
                        death_count_next = death_count_reg + 14'd1;
                    end
                end else if (key_edge) begin
                    state_next      = ST_RESPAWN;
                    level_rst_next  = 1'b1;
                    spawn_load_next = 1'b1;
                    rst_cnt_next    = '0;
                end
            end

            ST_DYING: begin
                // With zero freeze frames the first DYING cycle exits directly.
                if ((FREEZE_FRAMES == 0) || (frame_tick && (frame_cnt_reg == FF_LAST))) begin
                    state_next     = ST_DEAD;
                    game_over_next = 1'b1;
                end else if (frame_tick) begin
                    frame_cnt_next = frame_cnt_reg + 1'b1;
                end
            end

            ST_DEAD: begin
                if (key_edge) begin
                    state_next      = ST_RESPAWN;
                    kid_dead_next   = 1'b0;
                    game_over_next  = 1'b0;
                    level_rst_next  = 1'b1;
                    spawn_load_next = 1'b1;
                    rst_cnt_next    = '0;
                end
            end

            default: begin
                state_next     = ST_RESPAWN;
                boot_next      = 1'b1;
                level_rst_next = 1'b1;
                kid_dead_next  = 1'b0;
                game_over_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_RESPAWN;
            rst_cnt_reg     <= '0;
            frame_cnt_reg   <= '0;
            boot_reg        <= 1'b1;
            key_prev_reg    <= 1'b0;
            kid_dead_reg    <= 1'b0;
            game_over_reg   <= 1'b0;
            level_rst_reg   <= 1'b1;
            spawn_load_reg  <= 1'b0;
            death_count_reg <= '0;
            last_cause_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            rst_cnt_reg     <= rst_cnt_next;
            frame_cnt_reg   <= frame_cnt_next;
            boot_reg        <= boot_next;
            key_prev_reg    <= key_prev_next;
            kid_dead_reg    <= kid_dead_next;
            game_over_reg   <= game_over_next;
            level_rst_reg   <= level_rst_next;
            spawn_load_reg  <= spawn_load_next;
            death_count_reg <= death_count_next;
            last_cause_reg  <= last_cause_next;
        end
    end

    assign kid_dead    = kid_dead_reg;
    assign game_over   = game_over_reg;
    assign level_rst   = level_rst_reg;
    assign spawn_load  = spawn_load_reg;
    assign death_count = death_count_reg;
    assign last_cause  = last_cause_reg;
    assign spawn_x     = 10'(SPAWN_X);
    assign spawn_y     = 10'(SPAWN_Y);

endmodule
